pipeline_arbiter: RTL and testbench
===================================

PIPELINE_ARBITER -- requirements
Module: pipeline_arbiter

Interface
REQ-001 Parameter: NUM_PORTS, default 4, number of upstream requesters (2..8).
REQ-002 Parameter: DATA_WIDTH, default 32, payload width per beat.
REQ-003 Parameter: ID_WIDTH, default 2, grant index width, SHALL equal clog2(NUM_PORTS).
REQ-004 Ports (one clock; reset is synchronous and active-high):
  clk      input   1                      sole clock, rising edge
  rst      input   1                      synchronous, active-high reset
  u_data   input   NUM_PORTS*DATA_WIDTH   per-port payload, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
  u_valid  input   NUM_PORTS              per-port beat valid
  u_last   input   NUM_PORTS              per-port last beat of burst
  u_ready  output  NUM_PORTS              per-port ready, combinational
  d_data   output  DATA_WIDTH             registered payload to shared pipeline stage
  d_valid  output  1                      registered valid
  d_last   output  1                      registered last
  d_id     output  ID_WIDTH               registered index of the port that sourced d_data
  d_ready  input   1                      downstream ready
  busy     output  1                      high while a burst is granted

Function
REQ-010 Two-state FSM: IDLE, GRANT; busy SHALL be 1 exactly in GRANT.
REQ-011 IDLE: when any u_valid is 1, the arbiter SHALL select the first port with u_valid=1 searching upward from rr_ptr (modulo NUM_PORTS), latch it into grant_id, and go to GRANT next cycle.
REQ-012 IDLE: all u_ready SHALL be 0 (one-cycle arbitration bubble per burst).
REQ-013 GRANT: u_ready[grant_id] SHALL equal (d_ready | ~d_valid); all other u_ready SHALL be 0.
REQ-014 A beat transfers when u_valid[grant_id] & u_ready[grant_id]; on that edge d_data/d_last SHALL load the granted port's data/last, d_id SHALL load grant_id, and d_valid SHALL become 1.
REQ-015 If d_valid & d_ready and no new beat transfers, d_valid SHALL clear to 0 on that edge; if d_valid & ~d_ready, d_data/d_valid/d_last/d_id SHALL hold.
REQ-016 A transfer with u_last=1 SHALL return the FSM to IDLE and set rr_ptr = (grant_id+1) mod NUM_PORTS on the same edge.
REQ-017 The grant SHALL NOT change mid-burst regardless of other ports' u_valid.
REQ-018 Latency: u_valid asserted in IDLE at cycle T -> first beat on d_valid at T+2; within a burst with d_ready=1, one beat per cycle.
REQ-019 Outputs change only on clk edges except u_ready (REQ-013); d_* SHALL NOT depend combinationally on u_*.
REQ-020 Deasserting u_valid[grant_id] mid-burst SHALL stall without losing the grant.
REQ-021 Simultaneous request from all ports with rr_ptr=k: port k SHALL win.

Reset
REQ-030 On rst=1 at a clk edge: FSM=IDLE, rr_ptr=0, grant_id=0, d_valid=0, d_last=0, d_data=0, d_id=0, busy=0, u_ready=0 on the following cycle.
REQ-031 Reset mid-burst SHALL discard the in-flight beat and the grant; no partial burst resumes after release.
REQ-032 The first arbitration after reset release SHALL occur on the first cycle with rst=0.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding (IDLE=0, GRANT=1) and the clog2 helper for ID_WIDTH.
REQ-041 The round-robin priority search SHALL be a sub-module rr_select (inputs: request vector, rr_ptr; outputs: winner index, any_req), purely combinational.
REQ-042 The output register SHALL be in pipeline_arbiter itself; no extra skid buffer.

Verification
REQ-050 Single port: port 2 sends 3 beats (0xA0,0xA1,0xA2, last on 3rd), d_ready=1 -> d_data A0/A1/A2 on cycles T+2..T+4, d_id=2, d_last only on A2, busy falls after A2 transfer.
REQ-051 Fairness: all 4 ports request continuously with 1-beat bursts from reset -> grant order 0,1,2,3,0; each burst separated by one IDLE cycle.
REQ-052 Burst lock: port 0 in 4-beat burst, port 1 requests at beat 2 -> port 1 u_ready stays 0 until port 0 last transfers; port 1 granted next.
REQ-053 Backpressure: d_ready=0 for 5 cycles mid-burst -> d_data/d_id/d_valid held stable, no beat dropped or duplicated, u_ready[grant_id]=0 throughout.
REQ-054 Reset mid-burst: rst=1 after beat 2 of 4 -> next cycle d_valid=0, busy=0, rr_ptr=0; after release, port 0 wins if requesting.
REQ-055 Source stall: granted port drops u_valid for 3 cycles mid-burst -> d_valid=0 after drain, busy=1 held, burst resumes with same d_id.

Source files
------------

// File: rtl/pipeline_arbiter_pkg.sv
// Shared definitions for the pipeline arbiter: FSM encoding and the
// index-width helper used to size grant identifiers.
package pipeline_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_arbiter_rr_select.sv
// Round-robin priority search: the first requester at or above rr_ptr,
// wrapping modulo NUM_PORTS. Purely combinational.
module rr_select
  import pipeline_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = clog2_f(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  rr_ptr,
  output logic [ID_WIDTH-1:0]  winner,
  output logic                 any_req
);

  // Scan from the far end toward rr_ptr so the closest requester is written last.
  always_comb begin
    int idx;
    winner  = '0;
    any_req = |req;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (req[idx]) winner = ID_WIDTH'(idx);
    end
  end

endmodule

// File: rtl/pipeline_arbiter.sv
// Burst-locked round-robin arbiter feeding one registered pipeline stage.
// A grant lasts until the granted port transfers its last beat.
module pipeline_arbiter
  import pipeline_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = clog2_f(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] u_data,
  input  logic [NUM_PORTS-1:0]            u_valid,
  input  logic [NUM_PORTS-1:0]            u_last,
  output logic [NUM_PORTS-1:0]            u_ready,
  output logic [DATA_WIDTH-1:0]           d_data,
  output logic                            d_valid,
  output logic                            d_last,
  output logic [ID_WIDTH-1:0]             d_id,
  input  logic                            d_ready,
  output logic                            busy
);

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   winner;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  xfer;

  rr_select #(
    .NUM_PORTS(NUM_PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_select (
    .req    (u_valid),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any_req(any_req)
  );

  assign sel_data  = u_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_valid = u_valid[grant_id];
  assign sel_last  = u_last[grant_id];
  assign xfer      = (state == GRANT) && sel_valid && u_ready[grant_id];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (xfer && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    u_ready = '0;
    busy    = (state == GRANT);
    if (state == GRANT) u_ready[grant_id] = d_ready | ~d_valid;
  end

  // The grant index is captured only in IDLE, so it cannot move mid-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == IDLE && any_req) grant_id <= winner;
      if (xfer && sel_last)
        rr_ptr <= (grant_id == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // NOTE: the payload register is reset too, because zeroed d_data/d_id
  // after reset is part of the visible contract, not just d_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_last  <= 1'b0;
      d_data  <= '0;
      d_id    <= '0;
    end else if (xfer) begin
      d_valid <= 1'b1;
      d_last  <= sel_last;
      d_data  <= sel_data;
      d_id    <= grant_id;
    end else if (d_ready) begin
      d_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Scoreboard bench for pipeline_arbiter: per-port beat sources, an expected
// queue filled at stimulus time, and an independent output monitor.
module tb_pipeline_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } src_beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } exp_beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP*DW-1:0] u_data;
  logic [NP-1:0]    u_valid;
  logic [NP-1:0]    u_last;
  logic [NP-1:0]    u_ready;
  logic [DW-1:0]    d_data;
  logic             d_valid;
  logic             d_last;
  logic [IW-1:0]    d_id;
  logic             d_ready = 1'b1;
  logic             busy;

  logic [NP-1:0]    stall = '0;
  logic [NP-1:0]    fire;
  src_beat_t        src_q [NP][$];
  exp_beat_t        exp_q [$];
  int               n_checks = 0;
  int               n_fail   = 0;

  pipeline_arbiter #(
    .NUM_PORTS (NP),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .u_data (u_data),
    .u_valid(u_valid),
    .u_last (u_last),
    .u_ready(u_ready),
    .d_data (d_data),
    .d_valid(d_valid),
    .d_last (d_last),
    .d_id   (d_id),
    .d_ready(d_ready),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_src(input int port, input logic [DW-1:0] data, input logic last);
    src_beat_t b;
    b.data = data;
    b.last = last;
    src_q[port].push_back(b);
  endtask

  task automatic push_exp(input logic [DW-1:0] data, input logic [IW-1:0] id, input logic last);
    exp_beat_t e;
    e.data = data;
    e.id   = id;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_burst(input int port, input logic [DW-1:0] base, input int len);
    for (int k = 0; k < len; k++) begin
      push_src(port, base + DW'(k), k == len - 1);
      push_exp(base + DW'(k), IW'(port), k == len - 1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      done = (exp_q.size() == 0) && !d_valid &&
             (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
             (src_q[2].size() == 0) && (src_q[3].size() == 0);
    end
    check("drain_done", done, 1);
  endtask

  // Source driver: retires beats that handshook on the previous edge, then
  // presents each port's next beat; handshakes are sampled once inputs settle.
  initial begin
    u_valid = '0;
    u_data  = '0;
    u_last  = '0;
    fire    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        for (int i = 0; i < NP; i++) src_q[i].delete();
        fire = '0;
      end else begin
        for (int i = 0; i < NP; i++)
          if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      for (int i = 0; i < NP; i++) begin
        if (src_q[i].size() > 0 && !stall[i]) begin
          u_valid[i]          = 1'b1;
          u_data[i*DW +: DW]  = src_q[i][0].data;
          u_last[i]           = src_q[i][0].last;
        end else begin
          u_valid[i] = 1'b0;
          u_last[i]  = 1'b0;
        end
      end
      #1;
      fire = u_valid & u_ready & {NP{~rst}};
    end
  end

  // Output monitor: every downstream handshake must match the queue head.
  initial begin
    exp_beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && d_valid && d_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: actual=%0h id=%0d expected=none", d_data, d_id);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", d_data, e.data);
          check("beat_id", d_id, e.id);
          check("beat_last", d_last, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset();
    check("rst_d_valid", d_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_d_data", d_data, 0);
    check("rst_d_id", d_id, 0);
    check("rst_d_last", d_last, 0);
    #3 check("rst_u_ready", u_ready, 0);

    // Single port burst: first beat two cycles after the request.
    tick();
    push_burst(2, 32'hA0, 3);
    tick();
    check("single_busy_t1", busy, 1);
    check("single_valid_t1", d_valid, 0);
    tick();
    check("single_valid_t2", d_valid, 1);
    check("single_data_t2", d_data, 32'hA0);
    check("single_id_t2", d_id, 2);
    tick();
    check("single_busy_t3", busy, 1);
    check("single_last_t3", d_last, 0);
    tick();
    check("single_data_t4", d_data, 32'hA2);
    check("single_last_t4", d_last, 1);
    check("single_busy_t4", busy, 0);
    drain();

    // Fairness from reset: 1-beat bursts on all ports, port 0 twice.
    apply_reset();
    push_src(0, 32'h10, 1'b1);
    push_src(0, 32'h14, 1'b1);
    push_src(1, 32'h11, 1'b1);
    push_src(2, 32'h12, 1'b1);
    push_src(3, 32'h13, 1'b1);
    push_exp(32'h10, 0, 1'b1);
    push_exp(32'h11, 1, 1'b1);
    push_exp(32'h12, 2, 1'b1);
    push_exp(32'h13, 3, 1'b1);
    push_exp(32'h14, 0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("fair_busy", busy, k % 2);
      if (k % 2 == 0) begin
        check("fair_valid", d_valid, 1);
        check("fair_id", d_id, ((k / 2) - 1) % 4);
      end
    end
    drain();

    // Burst lock: port 1 requests during port 0's burst and must wait.
    push_burst(0, 32'hB0, 4);
    tick();
    tick();
    push_burst(1, 32'hC0, 2);
    #3 check("lock_ready_b1", u_ready, 4'b0001);
    tick();
    #3 check("lock_ready_b2", u_ready, 4'b0001);
    tick();
    #3 check("lock_ready_b3", u_ready, 4'b0001);
    tick();
    check("lock_last_b4", d_last, 1);
    check("lock_busy_b4", busy, 0);
    #3 check("lock_ready_idle", u_ready, 4'b0000);
    tick();
    check("lock_busy_p1", busy, 1);
    #3 check("lock_ready_p1", u_ready, 4'b0010);
    tick();
    check("lock_id_p1", d_id, 1);
    drain();

    // Backpressure: downstream stalls for five edges after the first beat.
    push_burst(3, 32'hD0, 4);
    tick();
    tick();
    check("bp_first", d_data, 32'hD0);
    d_ready = 1'b0;
    #3 check("bp_ready0", u_ready, 4'b0000);
    for (int k = 3; k <= 7; k++) begin
      tick();
      check("bp_hold_valid", d_valid, 1);
      check("bp_hold_data", d_data, 32'hD0);
      check("bp_hold_id", d_id, 3);
      if (k < 7) begin
        #3 check("bp_ready", u_ready, 4'b0000);
      end else begin
        d_ready = 1'b1;
      end
    end
    drain();

    // Reset mid-burst after moving rr_ptr away from zero.
    push_burst(1, 32'hE0, 1);
    tick();
    tick();
    check("rr_id_e0", d_id, 1);
    push_burst(2, 32'hF0, 4);
    tick();
    tick();
    tick();
    check("mid_beat2", d_data, 32'hF1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("mrst_valid", d_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_data", d_data, 0);
    check("mrst_id", d_id, 0);
    rst = 1'b0;
    push_burst(0, 32'h50, 1);
    push_burst(3, 32'h53, 1);
    #3 check("mrst_ready", u_ready, 4'b0000);
    tick();
    check("mrst_busy_rel", busy, 1);
    #3 check("mrst_winner", u_ready, 4'b0001);
    drain();

    // Source stall: granted port withholds valid for three cycles.
    push_burst(1, 32'h60, 4);
    tick();
    tick();
    check("stall_first", d_data, 32'h60);
    stall[1] = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      tick();
      check("stall_valid", d_valid, 0);
      check("stall_busy", busy, 1);
    end
    stall[1] = 1'b0;
    tick();
    check("stall_resume_valid", d_valid, 1);
    check("stall_resume_data", d_data, 32'h61);
    check("stall_resume_id", d_id, 1);
    drain();

    check("exp_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
